// File: rtl/multicycle_ctrl_gen.sv
// Multicycle MIPS control FSM with sized loads/stores, memory-wait timeout and err flag.
// Optional interrupt entry state enabled by defining MC_CTRL_INTR_EN.
module multicycle_ctrl_gen #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic        MIO_ready,
  input  logic        zero,
`ifdef MC_CTRL_INTR_EN
  input  logic        intr,
  output logic        intr_ack,
`endif
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        beq,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        cpu_mio,
  output logic        sign_ext,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  reg_dst,
  output logic [3:0]  alu_op,
  output logic [1:0]  mem_size,
  output logic        load_unsigned,
  output logic        err,
  output logic [4:0]  state_out
);

  typedef enum logic [4:0] {
    S_IF     = 5'd0,
    S_ID     = 5'd1,
    S_EX_R   = 5'd2,
    S_WB_R   = 5'd3,
    S_EX_I   = 5'd4,
    S_WB_I   = 5'd5,
    S_WB_LUI = 5'd6,
    S_EX_MEM = 5'd7,
    S_MEM_RD = 5'd8,
    S_WB_LD  = 5'd9,
    S_MEM_WR = 5'd10,
    S_EX_BR  = 5'd11,
    S_EX_J   = 5'd12,
    S_EX_JAL = 5'd13,
    S_EX_JR  = 5'd14,
    S_ERROR  = 5'd15,
    S_INT    = 5'd16
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MEM_WAIT_MAX);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_op;
  logic [5:0]       r_fn;
  logic             w_wait;
  logic             w_timeout;
  logic [4:0]       w_rdec;
  logic             w_unused;

  assign w_unused = ^{zero, Inst[25:6]};

  // {legal, alu_op} for R-type funct codes (jr handled separately)
  function automatic logic [4:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return {1'b1, 4'h2};
      6'h21:   return {1'b1, 4'h9};
      6'h22:   return {1'b1, 4'h6};
      6'h23:   return {1'b1, 4'hA};
      6'h24:   return {1'b1, 4'h0};
      6'h25:   return {1'b1, 4'h1};
      6'h26:   return {1'b1, 4'h3};
      6'h27:   return {1'b1, 4'h4};
      6'h2A:   return {1'b1, 4'h7};
      6'h2B:   return {1'b1, 4'hB};
      6'h00:   return {1'b1, 4'h8};
      6'h02:   return {1'b1, 4'h5};
      6'h03:   return {1'b1, 4'hE};
      default: return 5'b0;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(input logic [5:0] op);
    case (op)
      6'h09:   return 4'h9;
      6'h0A:   return 4'h7;
      6'h0B:   return 4'hB;
      6'h0C:   return 4'h0;
      6'h0D:   return 4'h1;
      6'h0E:   return 4'h3;
      default: return 4'h2;
    endcase
  endfunction

  assign w_rdec = r_alu(Inst[5:0]);
  assign w_wait = (r_state == S_IF) || (r_state == S_MEM_RD) ||
                  (r_state == S_MEM_WR);
  assign w_timeout = (MEM_WAIT_MAX != 0) && !MIO_ready &&
                     (r_cnt == LP_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IF;
      r_cnt   <= '0;
      r_op    <= '0;
      r_fn    <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_wait && !MIO_ready)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_ID) begin
        r_op <= Inst[31:26];
        r_fn <= Inst[5:0];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IF: begin
        if (MIO_ready)      w_next = S_ID;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_ID: begin
        case (Inst[31:26])
          6'h00: begin
            if (Inst[5:0] == 6'h08) w_next = S_EX_JR;
            else if (w_rdec[4])     w_next = S_EX_R;
            else                    w_next = S_ERROR;
          end
          6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
          6'h28, 6'h29, 6'h2B:        w_next = S_EX_MEM;
          6'h04, 6'h05:               w_next = S_EX_BR;
          6'h02:                      w_next = S_EX_J;
          6'h03:                      w_next = S_EX_JAL;
          6'h08, 6'h09, 6'h0A, 6'h0B,
          6'h0C, 6'h0D, 6'h0E:        w_next = S_EX_I;
          6'h0F:                      w_next = S_WB_LUI;
          default:                    w_next = S_ERROR;
        endcase
      end
      S_EX_R:   w_next = S_WB_R;
      S_EX_I:   w_next = S_WB_I;
      S_EX_MEM: w_next = r_op[3] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (MIO_ready)      w_next = S_WB_LD;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_MEM_WR: begin
        if (MIO_ready)      w_next = S_IF;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_WB_R, S_WB_I, S_WB_LUI, S_WB_LD,
      S_EX_BR, S_EX_J, S_EX_JAL, S_EX_JR,
      S_INT:    w_next = S_IF;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_ERROR;
    endcase
`ifdef MC_CTRL_INTR_EN
    // INT->IF must not re-enter INT, and staying in IF is not an entry
    if (w_next == S_IF && r_state != S_IF &&
        r_state != S_INT && intr)
      w_next = S_INT;
`endif
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    beq           = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    cpu_mio       = 1'b0;
    sign_ext      = 1'b0;
    mem_to_reg    = 2'b00;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    reg_dst       = 2'b00;
    alu_op        = 4'h0;
    mem_size      = 2'b00;
    load_unsigned = 1'b0;
`ifdef MC_CTRL_INTR_EN
    intr_ack      = 1'b0;
`endif
    case (r_state)
      S_IF: begin
        mem_read  = 1'b1;
        cpu_mio   = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 4'h2;
        ir_write  = MIO_ready;
        pc_write  = MIO_ready;
      end
      S_ID: begin
        alu_src_b = 2'b11;
        sign_ext  = 1'b1;
        alu_op    = 4'h2;
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu(r_fn)[3:0];
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        alu_op    = r_alu(r_fn)[3:0];
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        sign_ext  = (r_op[5:2] != 4'b0011);
        alu_op    = i_alu(r_op);
      end
      S_WB_I:   reg_write = 1'b1;
      S_WB_LUI: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
      end
      S_EX_MEM: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        sign_ext  = 1'b1;
        alu_op    = 4'h2;
      end
      S_MEM_RD, S_MEM_WR: begin
        mem_read      = (r_state == S_MEM_RD);
        mem_write     = (r_state == S_MEM_WR);
        i_or_d        = 1'b1;
        cpu_mio       = 1'b1;
        mem_size      = (r_op[1:0] == 2'b11) ? 2'b10 :
                        {1'b0, r_op[0]};
        load_unsigned = r_op[2];
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_EX_BR: begin
        alu_src_a     = 1'b1;
        sign_ext      = 1'b1;
        alu_op        = 4'h6;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        beq           = ~r_op[0];
      end
      S_EX_J: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_EX_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b11;
      end
      S_EX_JR: begin
        pc_write  = 1'b1;
        alu_src_a = 1'b1;
        alu_op    = 4'h2;
      end
`ifdef MC_CTRL_INTR_EN
      S_INT: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        intr_ack  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign err       = (r_state == S_ERROR);
  assign state_out = r_state;

endmodule
